// File: rtl/tdm_demux_if.sv
// tdm_demux_if: shared TDM bus input and demultiplexed channel outputs
interface tdm_demux_if #(parameter int W = 4);
  logic         in_valid;
  logic         in_sof;
  logic [W-1:0] in_data;
  logic [W-1:0] out1;
  logic [W-1:0] out2;
  logic [W-1:0] out3;
  logic [W-1:0] out4;
  logic         out_valid;
  logic [1:0]   slot;
  logic         frame_err;
  logic [7:0]   frame_cnt;
  modport master (
    output in_valid, in_sof, in_data,
    input  out1, out2, out3, out4, out_valid, slot, frame_err, frame_cnt
  );
  modport slave (
    input  in_valid, in_sof, in_data,
    output out1, out2, out3, out4, out_valid, slot, frame_err, frame_cnt
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: 1:4 nibble TDM receiver with SOF sync, frame-valid pulse and broken-frame detection
module tdm_demux #(
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst,
  tdm_demux_if.slave bus
);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t        state;
  logic [W-1:0]  s0, s1, s2;
  logic [IW-1:0] idle_cnt;
  // the T-th consecutive idle cycle is the one that finds the counter at T-1
  wire timed_out = (TIMEOUT != 0) && (idle_cnt == IW'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    bus.out_valid <= 1'b0;
    bus.frame_err <= 1'b0;
    if (rst) begin
      state         <= IDLE;
      bus.slot      <= 2'd0;
      bus.out1      <= '0;
      bus.out2      <= '0;
      bus.out3      <= '0;
      bus.out4      <= '0;
      bus.frame_cnt <= 8'd0;
      s0            <= '0;
      s1            <= '0;
      s2            <= '0;
      idle_cnt      <= '0;
    end else if (bus.in_valid) begin
      idle_cnt <= '0;
      if (bus.in_sof) begin
        bus.frame_err <= (state == COLLECT);
        s0            <= bus.in_data;
        bus.slot      <= 2'd1;
        state         <= COLLECT;
      end else if (state == COLLECT) begin
        if (bus.slot == 2'd3) begin
          bus.out1      <= s0;
          bus.out2      <= s1;
          bus.out3      <= s2;
          bus.out4      <= bus.in_data;
          bus.out_valid <= 1'b1;
          bus.frame_cnt <= bus.frame_cnt + 8'd1;
          bus.slot      <= 2'd0;
          state         <= IDLE;
        end else begin
          s1       <= (bus.slot == 2'd1) ? bus.in_data : s1;
          s2       <= (bus.slot == 2'd2) ? bus.in_data : s2;
          bus.slot <= bus.slot + 2'd1;
        end
      end
    end else if (state == COLLECT) begin
      if (timed_out) begin
        bus.frame_err <= 1'b1;
        bus.slot      <= 2'd0;
        idle_cnt      <= '0;
        state         <= IDLE;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: randomized + directed scoreboard bench for tdm_demux
module tb_tdm_demux;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  tdm_demux_if #(.W(4)) bus ();
  tdm_demux #(.W(4), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [25:0] exp_q[$];
  logic [3:0]  fq[$];
  logic [3:0]  m_out[4];
  logic [7:0]  m_cnt;
  logic [1:0]  m_slot;
  bit          in_frame;
  int          idle;
  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction
  function automatic logic [25:0] ev(logic ok);
    return {ok, !ok, m_out[0], m_out[1], m_out[2], m_out[3], m_cnt};
  endfunction
  // Frame-level model: a frame is a list of nibbles that completes at length 4
  task automatic model(input logic r, v, s, input logic [3:0] d);
    if (r) begin
      fq.delete(); in_frame = 0; idle = 0; m_cnt = 0;
      foreach (m_out[i]) m_out[i] = 4'd0;
    end else if (v) begin
      idle = 0;
      if (s) begin
        if (in_frame) exp_q.push_back(ev(1'b0));
        fq.delete(); fq.push_back(d); in_frame = 1;
      end else if (in_frame) begin
        fq.push_back(d);
        if (fq.size() == 4) begin
          foreach (m_out[i]) m_out[i] = fq[i];
          m_cnt++;
          exp_q.push_back(ev(1'b1));
          fq.delete(); in_frame = 0;
        end
      end
    end else if (in_frame) begin
      idle++;
      if (TO != 0 && idle == TO) begin
        exp_q.push_back(ev(1'b0));
        fq.delete(); in_frame = 0; idle = 0;
      end
    end
    m_slot = in_frame ? 2'(fq.size()) : 2'd0;
  endtask
  task automatic step(input logic r, v, s, input logic [3:0] d);
    rst = r; bus.in_valid = v; bus.in_sof = s; bus.in_data = d;
    model(r, v, s, d);
    @(posedge clk); #1;
    check("slot", 32'(bus.slot), 32'(m_slot));
  endtask
  task automatic frame(input logic [3:0] a, b, c, d);
    step(0, 1, 1, a); step(0, 1, 0, b); step(0, 1, 0, c); step(0, 1, 0, d);
  endtask
  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0);
  endtask
  task automatic check_reset();
    check("rst_outs", {bus.out1, bus.out2, bus.out3, bus.out4}, 32'd0);
    check("rst_cnt", 32'(bus.frame_cnt), 32'd0);
    check("rst_pulses", {bus.out_valid, bus.frame_err}, 32'd0);
  endtask
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 || bus.frame_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_pulse: got ov=%b fe=%b expected none at %0t", bus.out_valid, bus.frame_err, $time);
      end else begin
        check("event", 32'({bus.out_valid, bus.frame_err, bus.out1, bus.out2, bus.out3, bus.out4, bus.frame_cnt}),
              32'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    bus.in_valid = 0; bus.in_sof = 0; bus.in_data = 0;
    step(1, 0, 0, 4'd0); step(1, 0, 0, 4'd0);
    check_reset();
    frame(4'hA, 4'hE, 4'h5, 4'hC);
    idles(1);
    check("clean_cnt", 32'(bus.frame_cnt), 32'd1);
    step(0, 1, 1, 4'hB); step(0, 1, 0, 4'hE); idles(2); step(0, 1, 0, 4'h5); step(0, 1, 0, 4'hC);
    step(0, 1, 1, 4'h1); step(0, 1, 0, 4'h2); idles(TO); step(0, 1, 0, 4'h7); idles(3);
    check("timeout_hold", {bus.out1, bus.out2, bus.out3, bus.out4}, 32'hBE5C);
    step(0, 1, 1, 4'h1); step(0, 1, 0, 4'h2); frame(4'h6, 4'h7, 4'h8, 4'h9);
    idles(1);
    check("restart_cnt", 32'(bus.frame_cnt), 32'd3);
    step(1, 0, 0, 4'd0);
    for (int i = 0; i < 256; i++) frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    idles(1);
    check("wrap_cnt", 32'(bus.frame_cnt), 32'd0);
    step(0, 1, 1, 4'hF); step(0, 1, 0, 4'hF); step(1, 0, 0, 4'd0);
    check_reset();
    frame(4'h3, 4'h4, 4'h5, 4'h6);
    idles(1);
    check("post_rst", {bus.out1, bus.out2, bus.out3, bus.out4, bus.frame_cnt}, 32'h345601);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 40 == 0) idles($urandom_range(10, 18));
      else step($urandom % 500 == 0, $urandom % 4 != 0, $urandom % 5 == 0, 4'($urandom));
    end
    idles(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
